snoop_responder: RTL and testbench
==================================

Name: snoop_responder

Overview:
- Responding end of the L2 snoop interface. The cache core's snoop-result query is the initiating side.
- Takes a snooped bus operation from the external bus and looks up the line through the tag/MESI array port.
- Returns the snoop result (NOHIT/HIT/HITM) and writes back a Modified line before giving up ownership.
- Issues the resulting MESI update to the array. Sits between the bus-monitor front end and the L2 tag/MESI store.

Parameters:
- index_size, 14, set index width
- tag_size, 12, tag width
- offset_size, 6, line offset width (address width = tag_size+index_size+offset_size = 32)
- way_size, 3, way number width (8 ways)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- snoop_valid  input  1  snooped operation present
- snoop_ready  output  1  responder can accept (high only in IDLE)
- snoop_op  input  2  00 READ, 01 WRITE, 10 RWIM, 11 INVALIDATE
- snoop_addr  input  32  snooped byte address
- lookup_req  output  1  tag lookup request, held until ack
- lookup_index  output  index_size  captured index
- lookup_tag  output  tag_size  captured tag
- lookup_ack  input  1  lookup response valid
- lookup_hit  input  1  tag match, qualified by lookup_ack
- lookup_way  input  way_size  matching way
- lookup_mesi  input  2  I=00, S=01, E=10, M=11
- wb_req  output  1  writeback request, held until ack
- wb_addr  output  32  {tag, index, offset zeroed}
- wb_ack  input  1  writeback accepted
- upd_valid  output  1  one-cycle MESI update strobe
- upd_index  output  index_size  update set
- upd_way  output  way_size  update way
- upd_mesi  output  2  new state
- result_valid  output  1  one-cycle result strobe
- snoop_result  output  2  NOHIT=00, HIT=01, HITM=10; holds last value between strobes
- protocol_err  output  1  one-cycle pulse on an illegal snoop/state pairing

Behaviour:
- Reset: state IDLE. snoop_ready=1. All other outputs 0: lookup_req, wb_req, upd_valid, result_valid, protocol_err, snoop_result, and all address/index/way/mesi outputs.
- FSM states: IDLE, LOOKUP, WRITEBACK, UPDATE, RESP.
- IDLE: on snoop_valid&&snoop_ready, capture op, tag=addr[31:20], index=addr[19:6]; go to LOOKUP.
- LOOKUP: lookup_req=1 from the cycle after accept. A lookup_ack in the first cycle of lookup_req counts. On ack, capture way/mesi and decide:
  - Miss or mesi=I, any op: result NOHIT; go to RESP, no update.
  - READ, S or E: HIT; new state S. READ, M: HITM; go to WRITEBACK, then new state S.
  - RWIM, S or E: HIT; new state I. RWIM, M: HITM; go to WRITEBACK, then new state I.
  - INVALIDATE, S: HIT; new state I. INVALIDATE, E or M: protocol_err pulse; HIT; new state I; no writeback.
  - WRITE, valid line: protocol_err pulse; NOHIT; no update.
- Going to UPDATE or RESP: on an update, go to UPDATE next cycle, else to RESP.
- WRITEBACK: wb_req=1 with wb_addr stable until a wb_ack cycle, then UPDATE.
- UPDATE: upd_valid=1 for exactly one cycle, then RESP.
- RESP: result_valid=1 for exactly one cycle with snoop_result, then IDLE. snoop_ready rises the following cycle.
- Minimum latency with same-cycle acks, counting accept as cycle 0:
  - miss: lookup cycle 1, RESP cycle 2.
  - hit needing an update: UPDATE cycle 2, RESP cycle 3.
  - HITM: WRITEBACK cycle 2, UPDATE 3, RESP 4.
- Only one snoop in flight. snoop_valid outside IDLE is ignored; the source must hold it.
- Acks arriving when the matching req is low are ignored.
- Reset mid-operation: immediate return to IDLE. The in-flight snoop is dropped with no result, update or writeback strobe.

Optional Feature:
- SNOOP_STATS_EN defined adds output stat_hit 16, stat_hitm 16, stat_nohit 16.
- Each counter increments on the result_valid cycle for its result.
- Counters saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then READ 32'h1110_0040, miss (lookup_hit=0) -> snoop_result=00; no upd_valid/wb_req; result_valid at cycle 2.
- READ, hit, way 3, mesi E -> upd_valid index 14'h0401, way 3, upd_mesi 01; snoop_result 01; RESP at cycle 3.
- RWIM, hit, way 5, mesi M, wb_ack delayed 3 cycles -> wb_req held 3 cycles, wb_addr = snoop_addr&~32'h3F; upd_mesi 00; snoop_result 10.
- INVALIDATE on M and WRITE on S -> protocol_err one pulse each. INVALIDATE: upd_mesi 00, result 01. WRITE: no update, result 00.
- Reset asserted during WRITEBACK -> wb_req drops immediately; no result_valid; snoop_ready=1; next snoop processed normally.
- With SNOOP_STATS_EN, run 2 HIT, 1 HITM, 3 NOHIT -> stat_hit=2, stat_hitm=1, stat_nohit=3.

Source files
------------

// File: rtl/snoop_responder.sv
// Snoop responder: looks up a snooped address in the L2 tag/MESI array, returns NOHIT/HIT/HITM,
// writes back Modified lines, and issues the MESI update. Optional counters under `SNOOP_STATS_EN`.
module snoop_responder #(
    parameter int index_size  = 14,
    parameter int tag_size    = 12,
    parameter int offset_size = 6,
    parameter int way_size    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  snoop_valid,
    output logic                  snoop_ready,
    input  logic [1:0]            snoop_op,
    input  logic [31:0]           snoop_addr,
    output logic                  lookup_req,
    output logic [index_size-1:0] lookup_index,
    output logic [tag_size-1:0]   lookup_tag,
    input  logic                  lookup_ack,
    input  logic                  lookup_hit,
    input  logic [way_size-1:0]   lookup_way,
    input  logic [1:0]            lookup_mesi,
    output logic                  wb_req,
    output logic [31:0]           wb_addr,
    input  logic                  wb_ack,
    output logic                  upd_valid,
    output logic [index_size-1:0] upd_index,
    output logic [way_size-1:0]   upd_way,
    output logic [1:0]            upd_mesi,
    output logic                  result_valid,
    output logic [1:0]            snoop_result,
    output logic                  protocol_err
`ifdef SNOOP_STATS_EN
    ,
    output logic [15:0]           stat_hit,
    output logic [15:0]           stat_hitm,
    output logic [15:0]           stat_nohit
`endif
);

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_RWIM    = 2'b10;
    localparam logic [1:0] OP_INV     = 2'b11;
    localparam logic [1:0] MESI_I     = 2'b00;
    localparam logic [1:0] MESI_S     = 2'b01;
    localparam logic [1:0] MESI_M     = 2'b11;
    localparam logic [1:0] RES_NOHIT  = 2'b00;
    localparam logic [1:0] RES_HIT    = 2'b01;
    localparam logic [1:0] RES_HITM   = 2'b10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        UPDATE    = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [1:0]            op_q;
    logic [tag_size-1:0]   tag_q;
    logic [index_size-1:0] idx_q;
    logic [way_size-1:0]   way_q;
    logic [1:0]            mesi_q;
    logic [1:0]            pend_q;
    logic [1:0]            result_q;
    logic                  err_q;

    logic [1:0] dec_result;
    logic [1:0] dec_mesi;
    logic       dec_upd;
    logic       dec_wb;
    logic       dec_err;

    logic unused_offset;
    assign unused_offset = ^snoop_addr[offset_size-1:0];

    // Snoop/state decision table, meaningful only in the lookup_ack cycle.
    always_comb begin
        dec_result = RES_NOHIT;
        dec_mesi   = MESI_I;
        dec_upd    = 1'b0;
        dec_wb     = 1'b0;
        dec_err    = 1'b0;
        if (lookup_hit && (lookup_mesi != MESI_I)) begin
            case (op_q)
                OP_READ, OP_RWIM: begin
                    dec_upd  = 1'b1;
                    dec_mesi = (op_q == OP_READ) ? MESI_S : MESI_I;
                    if (lookup_mesi == MESI_M) begin
                        dec_result = RES_HITM;
                        dec_wb     = 1'b1;
                    end else begin
                        dec_result = RES_HIT;
                    end
                end
                OP_INV: begin
                    dec_upd    = 1'b1;
                    dec_mesi   = MESI_I;
                    dec_result = RES_HIT;
                    dec_err    = (lookup_mesi != MESI_S);
                end
                default: begin
                    dec_err = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (snoop_valid) next_state = LOOKUP;
            LOOKUP: begin
                if (lookup_ack) begin
                    if (dec_wb)       next_state = WRITEBACK;
                    else if (dec_upd) next_state = UPDATE;
                    else              next_state = RESP;
                end
            end
            WRITEBACK: if (wb_ack) next_state = UPDATE;
            UPDATE:    next_state = RESP;
            RESP:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= '0;
            tag_q    <= '0;
            idx_q    <= '0;
            way_q    <= '0;
            mesi_q   <= '0;
            pend_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= next_state;
            err_q <= 1'b0;
            if (state == IDLE && snoop_valid) begin
                op_q  <= snoop_op;
                tag_q <= snoop_addr[offset_size+index_size +: tag_size];
                idx_q <= snoop_addr[offset_size +: index_size];
            end
            if (state == LOOKUP && lookup_ack) begin
                pend_q <= dec_result;
                err_q  <= dec_err;
                if (dec_upd) begin
                    way_q  <= lookup_way;
                    mesi_q <= dec_mesi;
                end
            end
            // The visible result only changes on entry to RESP so it holds between strobes.
            if (next_state == RESP && state != RESP) begin
                result_q <= (state == LOOKUP) ? dec_result : pend_q;
            end
        end
    end

    assign snoop_ready  = (state == IDLE);
    assign lookup_req   = (state == LOOKUP);
    assign wb_req       = (state == WRITEBACK);
    assign upd_valid    = (state == UPDATE);
    assign result_valid = (state == RESP);
    assign lookup_index = idx_q;
    assign lookup_tag   = tag_q;
    assign wb_addr      = {tag_q, idx_q, {offset_size{1'b0}}};
    assign upd_index    = idx_q;
    assign upd_way      = way_q;
    assign upd_mesi     = mesi_q;
    assign snoop_result = result_q;
    assign protocol_err = err_q;

`ifdef SNOOP_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_hit   <= '0;
            stat_hitm  <= '0;
            stat_nohit <= '0;
        end else if (state == RESP) begin
            case (result_q)
                RES_HIT:   if (stat_hit != 16'hFFFF)   stat_hit   <= stat_hit + 16'd1;
                RES_HITM:  if (stat_hitm != 16'hFFFF)  stat_hitm  <= stat_hitm + 16'd1;
                default:   if (stat_nohit != 16'hFFFF) stat_nohit <= stat_nohit + 16'd1;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Self-checking bench for snoop_responder: directed plan cases plus randomized snoops
// checked against a rule-level reference model and an expected-result queue.
module tb_snoop_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        snoop_valid;
    logic        snoop_ready;
    logic [1:0]  snoop_op;
    logic [31:0] snoop_addr;
    logic        lookup_req;
    logic [13:0] lookup_index;
    logic [11:0] lookup_tag;
    logic        lookup_ack;
    logic        lookup_hit;
    logic [2:0]  lookup_way;
    logic [1:0]  lookup_mesi;
    logic        wb_req;
    logic [31:0] wb_addr;
    logic        wb_ack;
    logic        upd_valid;
    logic [13:0] upd_index;
    logic [2:0]  upd_way;
    logic [1:0]  upd_mesi;
    logic        result_valid;
    logic [1:0]  snoop_result;
    logic        protocol_err;
`ifdef SNOOP_STATS_EN
    logic [15:0] stat_hit;
    logic [15:0] stat_hitm;
    logic [15:0] stat_nohit;
`endif

    snoop_responder dut (
        .clk(clk), .reset(reset),
        .snoop_valid(snoop_valid), .snoop_ready(snoop_ready),
        .snoop_op(snoop_op), .snoop_addr(snoop_addr),
        .lookup_req(lookup_req), .lookup_index(lookup_index), .lookup_tag(lookup_tag),
        .lookup_ack(lookup_ack), .lookup_hit(lookup_hit), .lookup_way(lookup_way),
        .lookup_mesi(lookup_mesi),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_ack(wb_ack),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_way(upd_way), .upd_mesi(upd_mesi),
        .result_valid(result_valid), .snoop_result(snoop_result), .protocol_err(protocol_err)
`ifdef SNOOP_STATS_EN
        , .stat_hit(stat_hit), .stat_hitm(stat_hitm), .stat_nohit(stat_nohit)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q[$];
    logic [1:0] last_result = 2'b00;
    int m_hit = 0;
    int m_hitm = 0;
    int m_nohit = 0;

    typedef struct packed {
        logic [1:0] result;
        logic       upd;
        logic       wb;
        logic       err;
        logic [1:0] mesi;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: op 0 READ, 1 WRITE, 2 RWIM, 3 INVALIDATE; mesi I0 S1 E2 M3; result NOHIT0 HIT1 HITM2.
    function automatic exp_t model(input logic [1:0] op, input bit hit, input logic [1:0] mesi);
        exp_t e;
        e = '0;
        if (!hit || mesi == 2'd0) return e;
        if (op == 2'd1) begin
            e.err = 1'b1;
            return e;
        end
        e.upd    = 1'b1;
        e.mesi   = (op == 2'd0) ? 2'd1 : 2'd0;
        e.result = 2'd1;
        if (op == 2'd3) e.err = (mesi != 2'd1);
        else if (mesi == 2'd3) begin
            e.result = 2'd2;
            e.wb     = 1'b1;
        end
        return e;
    endfunction

    task automatic score_result(input logic [1:0] got);
        logic [1:0] exp;
        if (exp_q.size() == 0) begin
            check("result_unexpected", 32'(got), 32'hFF);
            return;
        end
        exp = exp_q.pop_front();
        check("snoop_result", 32'(got), 32'(exp));
        last_result = exp;
        case (exp)
            2'd1:    m_hit++;
            2'd2:    m_hitm++;
            default: m_nohit++;
        endcase
    endtask

    // Drives one snoop and plays the array/writeback side; d = lookup ack delay, w = wb ack delay.
    task automatic run_snoop(input logic [1:0] op, input logic [31:0] addr, input bit hit,
                             input logic [2:0] way, input logic [1:0] mesi, input int d, input int w);
        exp_t e;
        int cyc, lk_cnt, wb_cnt, upd_cnt, err_cnt, res_cyc, upd_cyc, guard;
        bit done;
        e = model(op, hit, mesi);
        lk_cnt = 0; wb_cnt = 0; upd_cnt = 0; err_cnt = 0; res_cyc = -1; upd_cyc = -1; done = 0;
        guard = 0;
        while (!snoop_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_accept", 32'(snoop_ready), 32'd1);
        snoop_valid = 1'b1;
        snoop_op    = op;
        snoop_addr  = addr;
        exp_q.push_back(e.result);
        @(negedge clk);
        check("result_hold", 32'(snoop_result), 32'(last_result));
        cyc = 1;
        while (!done && cyc < 60) begin
            snoop_valid = 1'b0;
            snoop_op    = 2'($urandom);
            snoop_addr  = $urandom;
            lookup_ack  = 1'b0;
            wb_ack      = 1'b0;
            lookup_hit  = 1'($urandom);
            lookup_way  = 3'($urandom);
            lookup_mesi = 2'($urandom);
            if (lookup_req) begin
                if (lk_cnt == 0) begin
                    check("lookup_index", 32'(lookup_index), 32'(addr[19:6]));
                    check("lookup_tag", 32'(lookup_tag), 32'(addr[31:20]));
                end
                snoop_valid = 1'($urandom_range(0, 1));
                if (lk_cnt == d) begin
                    lookup_ack  = 1'b1;
                    lookup_hit  = hit;
                    lookup_way  = way;
                    lookup_mesi = mesi;
                end
                lk_cnt++;
            end else begin
                lookup_ack = ($urandom_range(0, 3) == 0);
            end
            if (wb_req) begin
                if (wb_cnt == 0) check("wb_addr", wb_addr, addr & ~32'h3F);
                if (wb_cnt == w) wb_ack = 1'b1;
                wb_cnt++;
            end else begin
                wb_ack = ($urandom_range(0, 3) == 0);
            end
            if (upd_valid) begin
                upd_cnt++;
                upd_cyc = cyc;
                check("upd_index", 32'(upd_index), 32'(addr[19:6]));
                check("upd_way", 32'(upd_way), 32'(way));
                check("upd_mesi", 32'(upd_mesi), 32'(e.mesi));
            end
            if (protocol_err) err_cnt++;
            if (result_valid) begin
                res_cyc = cyc;
                done = 1;
                check("ready_in_resp", 32'(snoop_ready), 32'd0);
                score_result(snoop_result);
            end
            @(negedge clk);
            cyc++;
        end
        snoop_valid = 1'b0;
        lookup_ack  = 1'b0;
        wb_ack      = 1'b0;
        if (!done) begin
            check("result_timeout", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end else begin
            check("ready_after_resp", 32'(snoop_ready), 32'd1);
            check("lookup_cycles", 32'(lk_cnt), 32'(d + 1));
            check("upd_count", 32'(upd_cnt), 32'(e.upd));
            check("wb_cycles", 32'(wb_cnt), e.wb ? 32'(w + 1) : 32'd0);
            check("err_pulses", 32'(err_cnt), 32'(e.err));
            check("result_cycle", 32'(res_cyc),
                  32'(2 + d + int'(e.upd) + (e.wb ? 1 + w : 0)));
            if (e.upd) check("upd_cycle", 32'(upd_cyc), 32'(res_cyc - 1));
        end
    endtask

    task automatic reset_in_writeback();
        int wb_seen, cyc, strobes;
        wb_seen = 0;
        snoop_valid = 1'b1;
        snoop_op    = 2'd0;
        snoop_addr  = 32'hABCD_1280;
        @(negedge clk);
        snoop_valid = 1'b0;
        cyc = 1;
        while (cyc < 12) begin
            lookup_ack = 1'b0;
            if (lookup_req) begin
                lookup_ack  = 1'b1;
                lookup_hit  = 1'b1;
                lookup_way  = 3'd2;
                lookup_mesi = 2'd3;
            end
            if (wb_req) wb_seen++;
            if (wb_seen == 2) break;
            @(negedge clk);
            cyc++;
        end
        lookup_ack = 1'b0;
        check("rst_wb_reached", 32'(wb_seen), 32'd2);
        reset = 1'b1;
        #1;
        check("rst_wb_req", 32'(wb_req), 32'd0);
        check("rst_ready", 32'(snoop_ready), 32'd1);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_upd_valid", 32'(upd_valid), 32'd0);
        check("rst_snoop_result", 32'(snoop_result), 32'd0);
        last_result = 2'b00;
        m_hit = 0; m_hitm = 0; m_nohit = 0;
        @(negedge clk);
        reset = 1'b0;
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            strobes += int'(result_valid) + int'(upd_valid) + int'(wb_req);
        end
        check("rst_no_strobes", 32'(strobes), 32'd0);
    endtask

    initial begin
        int n_hit_dir, n_hitm_dir, n_nohit_dir;
        reset = 1'b1;
        snoop_valid = 1'b0; snoop_op = 2'd0; snoop_addr = '0;
        lookup_ack = 1'b0; lookup_hit = 1'b0; lookup_way = '0; lookup_mesi = '0;
        wb_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(snoop_ready), 32'd1);
        check("reset_outputs", {22'd0, lookup_req, wb_req, upd_valid, result_valid,
                                protocol_err, snoop_result, upd_mesi, 1'b0}, 32'd0);
        check("reset_addrs", 32'(lookup_index) | 32'(lookup_tag) | wb_addr | 32'(upd_index)
                             | 32'(upd_way), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_snoop(2'd0, 32'h1110_0040, 1'b0, 3'd0, 2'd0, 0, 0);
        run_snoop(2'd0, 32'h1111_0040, 1'b1, 3'd3, 2'd2, 0, 0);
        run_snoop(2'd2, 32'h2345_67C8, 1'b1, 3'd5, 2'd3, 0, 2);
        run_snoop(2'd3, 32'h0F0F_1240, 1'b1, 3'd1, 2'd3, 0, 0);
        run_snoop(2'd1, 32'h7777_0080, 1'b1, 3'd4, 2'd1, 1, 0);
        run_snoop(2'd0, 32'h0000_0000, 1'b1, 3'd0, 2'd3, 0, 0);
        run_snoop(2'd0, 32'hFFFF_FFFF, 1'b1, 3'd7, 2'd0, 2, 0);

        for (int i = 0; i < 40; i++) begin
            run_snoop(2'($urandom), $urandom, 1'($urandom_range(0, 1)), 3'($urandom),
                      2'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        reset_in_writeback();
        run_snoop(2'd2, 32'h5555_AA40, 1'b1, 3'd6, 2'd1, 0, 0);

        // Fixed mix after a reset: 2 HIT, 1 HITM, 3 NOHIT.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_result = 2'b00;
        m_hit = 0; m_hitm = 0; m_nohit = 0;
        @(negedge clk);
        run_snoop(2'd0, 32'h1000_0040, 1'b1, 3'd1, 2'd1, 0, 0);
        run_snoop(2'd2, 32'h2000_0080, 1'b1, 3'd2, 2'd2, 0, 0);
        run_snoop(2'd0, 32'h3000_00C0, 1'b1, 3'd3, 2'd3, 0, 1);
        run_snoop(2'd0, 32'h4000_0100, 1'b0, 3'd0, 2'd0, 0, 0);
        run_snoop(2'd1, 32'h5000_0140, 1'b1, 3'd0, 2'd0, 0, 0);
        run_snoop(2'd3, 32'h6000_0180, 1'b1, 3'd0, 2'd0, 1, 0);
        n_hit_dir = m_hit; n_hitm_dir = m_hitm; n_nohit_dir = m_nohit;
        check("mix_model_hit", 32'(n_hit_dir), 32'd2);
        check("mix_model_hitm", 32'(n_hitm_dir), 32'd1);
        check("mix_model_nohit", 32'(n_nohit_dir), 32'd3);
`ifdef SNOOP_STATS_EN
        check("stat_hit", 32'(stat_hit), 32'd2);
        check("stat_hitm", 32'(stat_hitm), 32'd1);
        check("stat_nohit", 32'(stat_nohit), 32'd3);
`endif
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
